fetch_byte_queue: RTL and testbench
===================================

# fetch_byte_queue

Byte-granular instruction fetch queue between the Sysbus fetch path and the x86-64 decoder. Accepts 8-byte little-endian fetch beats, stores them in a circular byte buffer, and presents the oldest 15 bytes as the decoder's instruction window. Advances by the decoder-reported instruction length `byte_incr` each cycle. Supports a redirect flush with a byte offset into the first refetched beat.

## Interface
Parameters:
- `DEPTH`, 32: queue capacity in bytes; power of two, at least 24.
- `BEAT_BYTES`, 8: bytes per fill beat (64-bit bus data).

Ports:
- `clk`  in  1: single clock. Everything is sampled on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `fill_valid`  in  1: fill beat present.
- `fill_data`  in  64: beat payload. Byte 0 is `fill_data[7:0]` and is the earliest in program order.
- `fill_ready`  out  1: queue can accept a beat this cycle.
- `flush`  in  1: redirect. Discards all queued bytes.
- `flush_offset`  in  3: with `flush`, the number of leading bytes to drop from the next accepted beat.
- `window`  out  120: bits `[0:119]`. Byte k is `window[8k:8k+7]`, and byte 0 is the oldest queued byte.
- `window_valid`  out  1: at least 15 bytes are queued.
- `byte_incr`  in  4: bytes consumed by the decoder this cycle. A value of 0 means no consumption.

## Operation
- State:
  - `mem[DEPTH]` bytes.
  - `head` and `tail` pointers, `$clog2(DEPTH)` bits, wrapping modulo DEPTH.
  - `count`, `$clog2(DEPTH)+1` bits.
  - `skip`, 3 bits.
- Reset: `head`, `tail`, `count` and `skip` are 0, and `mem` is all zeros. Resulting outputs:
  - `window` = 0
  - `window_valid` = 0
  - `fill_ready` = 1
- `fill_ready` = `!flush && (count <= DEPTH-BEAT_BYTES)`. It is computed from the registered `count` and ignores any same-cycle consume.
- Accept = `fill_valid && fill_ready`. On accept:
  - Write bytes `skip..7` of `fill_data` to `mem[tail]`, `mem[tail+1]`, and so on.
  - `tail` and `count` advance by `8-skip`.
  - `skip` clears to 0.
- Consume = `window_valid && byte_incr != 0`. On consume, `head` advances by `byte_incr` and `count` drops by `byte_incr`.
  - `byte_incr` of 0 has no effect.
  - A nonzero `byte_incr` while `!window_valid` is ignored.
- Simultaneous accept and consume: `count` ends as `count + (8-skip) - byte_incr`. Both pointers update in the same cycle.
- Flush takes priority over everything in that cycle:
  - `head` = `tail` = `count` = 0.
  - `skip` = `flush_offset`.
  - The fill beat is not accepted (`fill_ready` is low) and any consume is ignored.
  - `mem` contents are not cleared.
- `window_valid` = `count >= 15`.
- `window` byte k = `mem[(head+k) mod DEPTH]`, read combinationally from registered state. Bytes beyond `count` are stale and are meaningful only when `window_valid` is high.
- Pointer arithmetic is modulo DEPTH, so wrap is implicit with no special case.
- `count` never exceeds DEPTH, because `fill_ready` prevents overflow.
- The decoder must never report `byte_incr` > 15. Values of 1 to 15 are legal.

## Timing
- Fill-to-window latency is 1 cycle. A beat accepted at edge N is visible in `window` and `count` after edge N.
- A consume at edge N exposes the next instruction's bytes after edge N. Back-to-back consumes every cycle are supported.
- Flush at edge N:
  - `window_valid` is 0 after N.
  - `fill_ready` is 1 in cycle N+1.
  - The earliest `window_valid` is after edge N+2, when `flush_offset` = 0 and two beats are accepted at N+1 and N+2 (16 bytes).
- Reset asserted in the middle of operation behaves identically to the reset description above, on the next edge.
- `reset` overrides `flush`.

## Structure
- Shared package `fetch_pkg`:
  - `FETCH_WINDOW_BYTES` = 15
  - `BEAT_BYTES` = 8
  - `typedef logic[0:FETCH_WINDOW_BYTES*8-1] fetch_window_t`
  - `typedef logic[3:0] instr_len_t`
- The decoder imports the same types for its `buffer` input and `byte_incr` output.
- Single module with no sub-module. The circular byte store is a register array with per-byte write enables derived from `tail`, `skip` and the accept signal.

## Test plan
- Reset, then 2 beats of bytes 0x00..0x0F → after the second accept, `window_valid` = 1 and window bytes 0..14 = 0x00..0x0E.
- With 16 bytes queued, `byte_incr` = 3 → `count` = 13, `window_valid` = 0. Then one more beat 0x10..0x17 → `window_valid` = 1 and byte 0 = 0x03.
- Fill continuously with the decoder consuming 5 per cycle for 40 beats (crossing the wrap repeatedly) → window bytes stay monotonic, with none lost or duplicated.
- Fill until `count` = 25 → `fill_ready` = 0. A `byte_incr` of 2 in that cycle changes nothing, and `fill_ready` = 1 the next cycle with `count` = 23.
- `flush` with `flush_offset` = 5 while `fill_valid` is high → that beat is not accepted. Next beat 0xA0..0xA7 then 0xB0..0xB7 (11 bytes) gives `window_valid` = 0. After a third beat (19 bytes), window byte 0 = 0xA5.
- Reset asserted alongside `fill_valid` and `flush` → outputs at reset values on the next cycle, and nothing is written into the queue.

Source files
------------

// File: rtl/fetch_pkg.sv
// Types and sizes shared by the fetch byte queue and the x86-64 decoder.
package fetch_pkg;

    localparam int FETCH_WINDOW_BYTES = 15;
    localparam int BEAT_BYTES         = 8;

    typedef logic [0:FETCH_WINDOW_BYTES*8-1] fetch_window_t;
    typedef logic [3:0]                      instr_len_t;

endpackage : fetch_pkg

// File: rtl/fetch_byte_queue_if.sv
// Fill-beat, redirect and decoder-window signals between fetch, queue and decoder.
interface fetch_byte_queue_if;
    import fetch_pkg::*;

    logic          fill_valid;
    logic [63:0]   fill_data;
    logic          fill_ready;
    logic          flush;
    logic [2:0]    flush_offset;
    fetch_window_t window;
    logic          window_valid;
    instr_len_t    byte_incr;

    // master: the fetch/decoder side driving beats, redirects and consumption
    modport master (
        output fill_valid, fill_data, flush, flush_offset, byte_incr,
        input  fill_ready, window, window_valid
    );

    modport slave (
        input  fill_valid, fill_data, flush, flush_offset, byte_incr,
        output fill_ready, window, window_valid
    );

endinterface : fetch_byte_queue_if

// File: rtl/fetch_byte_queue.sv
// Circular byte queue of fetch beats presenting the oldest 15 bytes to the decoder; fill-to-window 1 cycle.
// fill_ready drops when a full beat might not fit (registered count only) or during a flush.
module fetch_byte_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int BEAT_BYTES = fetch_pkg::BEAT_BYTES
) (
    input  logic               clk,
    input  logic               reset,
    fetch_byte_queue_if.slave  q_if
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    ptr_t          head_q, head_d;
    ptr_t          tail_q, tail_d;
    cnt_t          count_q, count_d;
    logic [2:0]    skip_q, skip_d;

    logic          accept;
    logic          consume;
    cnt_t          beat_len;
    cnt_t          used_len;
    fetch_window_t win;

    assign q_if.fill_ready   = !q_if.flush && (count_q <= cnt_t'(DEPTH - BEAT_BYTES));
    assign q_if.window_valid = (count_q >= cnt_t'(FETCH_WINDOW_BYTES));

    assign accept   = q_if.fill_valid && q_if.fill_ready;
    assign consume  = q_if.window_valid && (q_if.byte_incr != '0) && !q_if.flush;
    assign beat_len = cnt_t'(BEAT_BYTES) - cnt_t'(skip_q);
    assign used_len = cnt_t'(q_if.byte_incr);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        skip_d  = skip_q;
        mem_d   = mem_q;
        if (q_if.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            skip_d  = q_if.flush_offset;
        end else begin
            if (accept) begin
                // leading bytes below skip belong to the pre-redirect path
                for (int b = 0; b < BEAT_BYTES; b++) begin
                    if (3'(b) >= skip_q) begin
                        mem_d[tail_q + ptr_t'(b) - ptr_t'(skip_q)] = q_if.fill_data[8*b +: 8];
                    end
                end
                tail_d = tail_q + ptr_t'(beat_len);
                skip_d = '0;
            end
            if (consume) begin
                head_d = head_q + ptr_t'(q_if.byte_incr);
            end
            count_d = count_q + (accept ? beat_len : '0) - (consume ? used_len : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            skip_q  <= '0;
            mem_q   <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            skip_q  <= skip_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        win = '0;
        for (int k = 0; k < FETCH_WINDOW_BYTES; k++) begin
            win[8*k +: 8] = mem_q[head_q + ptr_t'(k)];
        end
    end

    assign q_if.window = win;

endmodule : fetch_byte_queue

// File: tb/tb_fetch_byte_queue.sv
// Scoreboard bench for fetch_byte_queue: a byte queue model tracks every accepted and consumed byte.
module tb_fetch_byte_queue;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_byte_queue_if q_if();

    fetch_byte_queue #(.DEPTH(32), .BEAT_BYTES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .q_if  (q_if)
    );

    int         n_checks = 0;
    int         n_errs   = 0;
    logic [7:0] sb [$];
    logic [2:0] m_skip   = 3'd0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_beat(input logic [7:0] base);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    // One clock: drive inputs, check fill_ready, update the model, then check the window after the edge.
    task automatic cycle(input logic rst, input logic fv, input logic [63:0] d,
                         input logic fl, input logic [2:0] off, input logic [3:0] incr,
                         output logic acc);
        logic          exp_rdy;
        fetch_window_t exp_win;
        reset             = rst;
        q_if.fill_valid   = fv;
        q_if.fill_data    = d;
        q_if.flush        = fl;
        q_if.flush_offset = off;
        q_if.byte_incr    = incr;
        #1;
        exp_rdy = !fl && (sb.size() <= 24);
        check("fill_ready", {127'd0, q_if.fill_ready}, {127'd0, exp_rdy});
        acc = 1'b0;
        if (rst) begin
            sb.delete();
            m_skip = 3'd0;
        end else if (fl) begin
            sb.delete();
            m_skip = off;
        end else begin
            if (sb.size() >= 15 && incr != 4'd0) repeat (incr) void'(sb.pop_front());
            if (fv && exp_rdy) begin
                for (int i = int'(m_skip); i < 8; i++) sb.push_back(d[8*i +: 8]);
                m_skip = 3'd0;
                acc    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("window_valid", {127'd0, q_if.window_valid}, {127'd0, sb.size() >= 15});
        if (rst) begin
            check("window_reset", 128'(q_if.window), 128'd0);
        end else if (sb.size() >= 15) begin
            for (int k = 0; k < 15; k++) exp_win[8*k +: 8] = sb[k];
            check("window", 128'(q_if.window), 128'(exp_win));
        end
    endtask

    initial begin
        logic       acc;
        logic [7:0] base;
        int         beats;

        reset             = 1'b1;
        q_if.fill_valid   = 1'b0;
        q_if.fill_data    = '0;
        q_if.flush        = 1'b0;
        q_if.flush_offset = '0;
        q_if.byte_incr    = '0;
        @(posedge clk);
        #1;
        cycle(1, 0, 64'd0, 0, 3'd0, 4'd0, acc);

        // two beats of 0x00..0x0F
        cycle(0, 1, mk_beat(8'h00), 0, 3'd0, 4'd0, acc);
        cycle(0, 1, mk_beat(8'h08), 0, 3'd0, 4'd0, acc);
        check("first_win_b0",  128'(q_if.window[0:7]),     128'h00);
        check("first_win_b14", 128'(q_if.window[112:119]), 128'h0E);

        // consume 3 -> 13 bytes, then one more beat
        cycle(0, 0, 64'd0, 0, 3'd0, 4'd3, acc);
        cycle(0, 1, mk_beat(8'h10), 0, 3'd0, 4'd0, acc);
        check("after_consume_b0", 128'(q_if.window[0:7]), 128'h03);

        // continuous fill while decoding 5 bytes per cycle
        base  = 8'h18;
        beats = 0;
        for (int c = 0; c < 400 && beats < 40; c++) begin
            cycle(0, 1, mk_beat(base), 0, 3'd0, 4'd5, acc);
            if (acc) begin
                base = base + 8'd8;
                beats++;
            end
        end
        check("stream_beats", 128'(beats), 128'd40);

        // fill to 25 bytes: flush with offset 7 then four beats
        cycle(0, 1, mk_beat(8'h30), 1, 3'd7, 4'd0, acc);
        check("flush_beat_dropped", {127'd0, acc}, 128'd0);
        cycle(0, 1, mk_beat(8'h40), 0, 3'd0, 4'd0, acc);
        cycle(0, 1, mk_beat(8'h48), 0, 3'd0, 4'd0, acc);
        cycle(0, 1, mk_beat(8'h50), 0, 3'd0, 4'd0, acc);
        cycle(0, 1, mk_beat(8'h58), 0, 3'd0, 4'd0, acc);
        check("skip7_b0", 128'(q_if.window[0:7]), 128'h47);
        cycle(0, 1, mk_beat(8'h60), 0, 3'd0, 4'd2, acc);
        check("full_not_accepted", {127'd0, acc}, 128'd0);
        cycle(0, 1, mk_beat(8'h60), 0, 3'd0, 4'd0, acc);
        check("after_full_accepted", {127'd0, acc}, 128'd1);

        // redirect with offset 5 while a beat is offered
        cycle(0, 1, mk_beat(8'hF0), 1, 3'd5, 4'd0, acc);
        check("flush5_beat_dropped", {127'd0, acc}, 128'd0);
        cycle(0, 1, mk_beat(8'hA0), 0, 3'd0, 4'd0, acc);
        cycle(0, 1, mk_beat(8'hB0), 0, 3'd0, 4'd0, acc);
        cycle(0, 0, 64'd0, 0, 3'd0, 4'd4, acc);
        cycle(0, 1, mk_beat(8'hC0), 0, 3'd0, 4'd0, acc);
        check("redirect_b0", 128'(q_if.window[0:7]), 128'hA5);

        // reset overriding fill and flush mid-operation
        cycle(1, 1, mk_beat(8'hE0), 1, 3'd6, 4'd3, acc);
        cycle(0, 0, 64'd0, 0, 3'd0, 4'd0, acc);
        cycle(0, 1, mk_beat(8'h80), 0, 3'd0, 4'd0, acc);
        cycle(0, 1, mk_beat(8'h88), 0, 3'd0, 4'd0, acc);
        check("post_reset_b0", 128'(q_if.window[0:7]), 128'h80);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_fetch_byte_queue
